// File: rtl/lzss_enc_param_if.sv
// Handshake/bus bundle for the LZSS encoder.
//   data        : IN_CHARS symbols, data[CHAR_W-1:0] is the first symbol
//   data_valid  : word offered
//   drop_done   : one-cycle pulse, no further words will follow
//   busy        : low means a word offered this cycle is accepted
//   codeword    : encoded token (literal or match)
//   enc_num     : count of codewords emitted (saturating)
//   out_valid   : codeword valid, one cycle per token
//   finish      : encoding complete
// master = word producer / token consumer, slave = encoder.
interface lzss_enc_param_if #(
  parameter int unsigned CHAR_W   = 8,
  parameter int unsigned IN_CHARS = 4,
  parameter int unsigned CW       = 9
);
  logic [IN_CHARS*CHAR_W-1:0] data;
  logic                       data_valid;
  logic                       drop_done;
  logic                       busy;
  logic [CW-1:0]              codeword;
  logic [11:0]                enc_num;
  logic                       out_valid;
  logic                       finish;

  modport master (
    output data, data_valid, drop_done,
    input  busy, codeword, enc_num, out_valid, finish
  );

  modport slave (
    input  data, data_valid, drop_done,
    output busy, codeword, enc_num, out_valid, finish
  );
endinterface

// File: rtl/lzss_enc_param.sv
// Parameterised LZSS encoder.
// Words of IN_CHARS symbols are loaded into a look-ahead (LA) buffer; each token is found
// by a one-cycle parallel search of the LA against the search buffer (SB) and emitted in
// the following cycle, after which the consumed symbols retire from the LA into the SB.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of lzss_enc_param_if (data/data_valid/drop_done in,
//           busy/codeword/enc_num/out_valid/finish out)
// Build option: define LZSS_OVERLAP_EN to let a match run past the newest SB symbol into
// the LA itself (len > offset+1); without it, len <= offset+1.
module lzss_enc_param #(
  parameter int unsigned CHAR_W       = 8,
  parameter int unsigned IN_CHARS     = 4,
  parameter int unsigned SEARCH_DEPTH = 8,
  parameter int unsigned LA_DEPTH     = 4
) (
  input logic            clk,
  input logic            reset,
  lzss_enc_param_if.slave bus
);
  localparam int unsigned OFF_W   = $clog2(SEARCH_DEPTH);
  localparam int unsigned LEN_W   = $clog2(LA_DEPTH + 1);
  localparam int unsigned CW      = 1 + ((CHAR_W > OFF_W + LEN_W) ? CHAR_W : OFF_W + LEN_W);
  localparam int unsigned SbW     = SEARCH_DEPTH * CHAR_W;
  localparam int unsigned LaW     = LA_DEPTH * CHAR_W;
  localparam int unsigned SbFillW = OFF_W + 1;
  localparam int unsigned Thresh  = LA_DEPTH - IN_CHARS;
`ifdef LZSS_OVERLAP_EN
  localparam bit OverlapEn = 1'b1;
`else
  localparam bit OverlapEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StLoad, StSearch, StEmit, StDone} state_e;

  state_e               state_q, state_d;
  // LA: symbol 0 (next to encode) in the LSBs. SB: newest symbol in the MSBs, so
  // {la, sb} is the stream in order and retiring n symbols is a right shift.
  logic [LaW-1:0]       la_q, la_d;
  logic [SbW-1:0]       sb_q, sb_d;
  logic [LEN_W-1:0]     la_fill_q, la_fill_d;
  logic [SbFillW-1:0]   sb_fill_q, sb_fill_d;
  logic                 last_q, last_d;
  logic                 busy_q, busy_d;
  logic [CW-1:0]        codeword_q, codeword_d;
  logic [11:0]          enc_num_q, enc_num_d;
  logic                 out_valid_q, out_valid_d;
  logic                 finish_q, finish_d;

  logic [LaW+SbW-1:0]   cat, cat_shift;
  logic [LEN_W-1:0]     best_len, len_c, shift_c;
  logic [OFF_W-1:0]     best_off;
  logic                 run_c;
  logic [CW-1:0]        cw_c;
  int                   sb_sum;

  assign cat = {la_q, sb_q};

  // Parallel match search; offset o compares SB symbol at distance o+1 onwards.
  always_comb begin
    best_len = '0;
    best_off = '0;
    len_c    = '0;
    run_c    = 1'b0;
    for (int o = 0; o < SEARCH_DEPTH; o++) begin
      len_c = '0;
      run_c = 1'b1;
      for (int i = 0; i < LA_DEPTH; i++) begin
        if (run_c && (i < int'(la_fill_q)) && (OverlapEn || (i <= o)) &&
            (cat[(SEARCH_DEPTH - 1 - o + i) * CHAR_W +: CHAR_W] ==
             cat[(SEARCH_DEPTH + i) * CHAR_W +: CHAR_W])) begin
          len_c = len_c + LEN_W'(1);
        end else begin
          run_c = 1'b0;
        end
      end
      // Strictly longer only, so ties keep the smallest offset.
      if ((o < int'(sb_fill_q)) && (len_c > best_len)) begin
        best_len = len_c;
        best_off = OFF_W'(o);
      end
    end

    cw_c = '0;
    if (best_len >= LEN_W'(2)) begin
      cw_c[CW-1]                = 1'b1;
      cw_c[OFF_W+LEN_W-1:0]     = {best_off, best_len};
      shift_c                   = best_len;
    end else begin
      cw_c[CHAR_W-1:0]          = la_q[CHAR_W-1:0];
      shift_c                   = LEN_W'(1);
    end
    cat_shift = cat >> (int'(shift_c) * CHAR_W);
  end

  always_comb begin
    state_d     = state_q;
    la_d        = la_q;
    sb_d        = sb_q;
    la_fill_d   = la_fill_q;
    sb_fill_d   = sb_fill_q;
    last_d      = last_q | bus.drop_done;
    codeword_d  = '0;
    out_valid_d = 1'b0;
    enc_num_d   = enc_num_q;
    sb_sum      = int'(sb_fill_q) + int'(shift_c);

    unique case (state_q)
      StIdle: state_d = StLoad;
      StLoad: begin
        if (bus.data_valid && !busy_q) begin
          la_d      = la_q | (LaW'(bus.data) << (int'(la_fill_q) * CHAR_W));
          la_fill_d = la_fill_q + LEN_W'(IN_CHARS);
        end
        if (la_fill_d > LEN_W'(Thresh)) begin
          state_d = StSearch;
        end else if (last_d) begin
          state_d = (la_fill_d != '0) ? StSearch : StDone;
        end
      end
      StSearch: begin
        codeword_d   = cw_c;
        out_valid_d  = 1'b1;
        enc_num_d    = (enc_num_q == 12'hFFF) ? enc_num_q : enc_num_q + 12'd1;
        {la_d, sb_d} = cat_shift;
        la_fill_d    = la_fill_q - shift_c;
        sb_fill_d    = (sb_sum > int'(SEARCH_DEPTH)) ? SbFillW'(SEARCH_DEPTH) : SbFillW'(sb_sum);
        state_d      = StEmit;
      end
      StEmit: begin
        if ((la_fill_q > LEN_W'(Thresh)) || (last_d && (la_fill_q != '0))) begin
          state_d = StSearch;
        end else begin
          state_d = StLoad;
        end
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase

    busy_d   = (state_d != StLoad);
    finish_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      la_q        <= '0;
      sb_q        <= '0;
      la_fill_q   <= '0;
      sb_fill_q   <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b1;
      codeword_q  <= '0;
      enc_num_q   <= '0;
      out_valid_q <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      la_q        <= la_d;
      sb_q        <= sb_d;
      la_fill_q   <= la_fill_d;
      sb_fill_q   <= sb_fill_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      codeword_q  <= codeword_d;
      enc_num_q   <= enc_num_d;
      out_valid_q <= out_valid_d;
      finish_q    <= finish_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.codeword  = codeword_q;
  assign bus.enc_num   = enc_num_q;
  assign bus.out_valid = out_valid_q;
  assign bus.finish    = finish_q;
endmodule

// File: tb/tb_lzss_enc_param.sv
module tb_lzss_enc_param;
  logic clk = 1'b0;
  logic reset = 1'b1;

  lzss_enc_param_if #(.CHAR_W(8), .IN_CHARS(4), .CW(9)) bus ();

  lzss_enc_param #(
    .CHAR_W      (8),
    .IN_CHARS    (4),
    .SEARCH_DEPTH(8),
    .LA_DEPTH    (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

`ifdef LZSS_OVERLAP_EN
  localparam bit Ov = 1'b1;
`else
  localparam bit Ov = 1'b0;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int          tok_seen = 0;
  int          exp_total = 0;
  logic [31:0] stim_q[$];
  logic [8:0]  model_q[$];
  logic [8:0]  exp_q[$];
  logic [8:0]  got_q[$];

  function automatic void chk(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, req, $time);
    end
  endfunction

  // Reference encoder on the symbol stream. At these parameters the LA is refilled only
  // when empty, so the LA for a search is the rest of the current input word.
  function automatic void model_encode();
    logic [7:0] s[$];
    int p, e, bl, bo, l;
    model_q.delete();
    foreach (stim_q[w]) for (int k = 0; k < 4; k++) s.push_back(stim_q[w][k*8 +: 8]);
    p = 0;
    while (p < s.size()) begin
      e  = (p / 4 + 1) * 4;
      bl = 0;
      bo = 0;
      for (int d = 1; d <= 8 && d <= p; d++) begin
        l = 0;
        while (p + l < e && (Ov || l < d) && s[p+l-d] == s[p+l]) l++;
        if (l > bl) begin
          bl = l;
          bo = d - 1;
        end
      end
      if (bl >= 2) begin
        model_q.push_back({1'b1, 2'b00, 3'(bo), 3'(bl)});
        p += bl;
      end else begin
        model_q.push_back({1'b0, s[p]});
        p++;
      end
    end
  endfunction

  function automatic int decode_errs();
    logic [7:0] s[$];
    logic [7:0] o[$];
    int errs = 0;
    int off, len;
    foreach (stim_q[w]) for (int k = 0; k < 4; k++) s.push_back(stim_q[w][k*8 +: 8]);
    foreach (got_q[j]) begin
      if (got_q[j][8]) begin
        off = int'(got_q[j][5:3]);
        len = int'(got_q[j][2:0]);
        for (int k = 0; k < len; k++) begin
          if (o.size() > off) o.push_back(o[o.size()-1-off]);
          else errs++;
        end
      end else begin
        o.push_back(got_q[j][7:0]);
      end
    end
    if (o.size() != s.size()) errs++;
    else foreach (s[k]) if (s[k] != o[k]) errs++;
    return errs;
  endfunction

  // Output checker, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid) begin
        tok_seen++;
        got_q.push_back(bus.codeword);
        if (exp_q.size() == 0) chk("token_overrun", tok_seen, exp_total);
        else chk("codeword", int'(bus.codeword), int'(exp_q.pop_front()));
        chk("busy_during_emit", int'(bus.busy), 1);
      end else begin
        chk("codeword_idle_zero", int'(bus.codeword), 0);
      end
      if (bus.finish) chk("done_quiet", int'({bus.busy, bus.out_valid}), 2);
    end
  end

  task automatic check_reset_values();
    chk("rst_busy", int'(bus.busy), 1);
    chk("rst_codeword", int'(bus.codeword), 0);
    chk("rst_enc_num", int'(bus.enc_num), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_finish", int'(bus.finish), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    bus.data_valid = 1'b0;
    bus.drop_done  = 1'b0;
    bus.data       = '0;
    #1;
    check_reset_values();
    model_encode();
    exp_q     = model_q;
    exp_total = model_q.size();
    got_q.delete();
    tok_seen = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_to_load_busy", int'(bus.busy), 0);
  endtask

  task automatic drive(input bit drop_with_last, input bit gaps);
    foreach (stim_q[w]) begin
      bit done;
      int cyc;
      done = 1'b0;
      cyc  = 0;
      while (!done) begin
        bus.data       = stim_q[w];
        bus.data_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        done           = bus.data_valid && !bus.busy;
        bus.drop_done  = done && drop_with_last && (w == stim_q.size() - 1);
        @(negedge clk);
        cyc++;
        if (!done && cyc > 500) begin
          chk("accept_timeout", cyc, 0);
          return;
        end
      end
    end
    bus.data_valid = 1'b0;
    bus.drop_done  = 1'b0;
    if (!drop_with_last) begin
      bus.drop_done = 1'b1;
      @(negedge clk);
      bus.drop_done = 1'b0;
    end
  endtask

  task automatic wait_finish();
    int cyc = 0;
    while (!bus.finish && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("finish_reached", int'(bus.finish), 1);
    repeat (3) @(negedge clk);
    chk("finish_held", int'(bus.finish), 1);
    chk("enc_num", int'(bus.enc_num), exp_total);
    chk("tokens_left", exp_q.size(), 0);
    chk("decode_roundtrip", decode_errs(), 0);
  endtask

  task automatic run_case(input bit drop_with_last, input bit gaps);
    do_reset();
    drive(drop_with_last, gaps);
    wait_finish();
  endtask

  initial begin
    int cyc;
    int nw;
    logic [31:0] w;
    bus.data       = '0;
    bus.data_valid = 1'b0;
    bus.drop_done  = 1'b0;

    // "AAAA" with drop_done on the same word.
    stim_q.delete();
    stim_q.push_back(32'h41414141);
    model_encode();
`ifdef LZSS_OVERLAP_EN
    chk("model_aaaa_count", model_q.size(), 2);
    chk("model_aaaa_0", int'(model_q[0]), 'h041);
    chk("model_aaaa_1", int'(model_q[1]), 'h103);
`else
    chk("model_aaaa_count", model_q.size(), 3);
    chk("model_aaaa_0", int'(model_q[0]), 'h041);
    chk("model_aaaa_1", int'(model_q[1]), 'h041);
    chk("model_aaaa_2", int'(model_q[2]), 'h10A);
`endif
    run_case(1'b1, 1'b0);

    // "ABCD" twice, drop_done afterwards.
    stim_q.delete();
    stim_q.push_back(32'h44434241);
    stim_q.push_back(32'h44434241);
    model_encode();
    chk("model_abcd_count", model_q.size(), 5);
    chk("model_abcd_0", int'(model_q[0]), 'h041);
    chk("model_abcd_3", int'(model_q[3]), 'h044);
    chk("model_abcd_4", int'(model_q[4]), 'h11C);
    run_case(1'b0, 1'b0);

    // drop_done with no words.
    stim_q.delete();
    run_case(1'b0, 1'b0);

    // Random streams over a small alphabet so matches are frequent.
    for (int t = 0; t < 12; t++) begin
      stim_q.delete();
      nw = $urandom_range(1, 10);
      for (int i = 0; i < nw; i++) begin
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'h41 + 8'($urandom_range(0, 2));
        stim_q.push_back(w);
      end
      run_case(1'(t % 2), (t % 3) == 0);
    end

    // Reset during the third EMIT, then a clean rerun of the same stimulus.
    stim_q.delete();
    stim_q.push_back(32'h44434241);
    do_reset();
    drive(1'b1, 1'b0);
    cyc = 0;
    while (tok_seen < 3 && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("third_emit_reached", tok_seen, 3);
    chk("in_third_emit", int'(bus.out_valid), 1);
    reset = 1'b1;
    #1;
    check_reset_values();
    run_case(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
